// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory port arbiter.
//   state_t : arbiter sequencer states (IDLE, ACCESS, RESP)
//   gnt_t   : which requester currently owns the memory (GNT_IF, GNT_DM)
//   DEF_*   : default parameter values used by mem_port_arbiter
package mem_arb_pkg;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_IF_ADDR_W   = 8;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// wait_counter: loadable down-counter that times the memory access window.
//   clk, reset : clock, asynchronous active-low reset
//   load_i     : reload with WAIT_CYCLES (asserted while the arbiter is idle)
//   en_i       : count down (asserted during ACCESS)
//   done_o     : high on the final ACCESS cycle (count reached zero while enabled)
module wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int            CW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LOAD = CW'(WAIT_CYCLES);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at zero so it can never wrap inside an access.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = LOAD;
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// (if_*) and the data-memory stage (dm_*). Each granted request runs
// IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP (one-cycle ack) -> IDLE.
//   clk, reset        : clock, asynchronous active-low reset
//   if_req/if_addr    : fetch request (level) and zero-extended fetch address
//   if_rdata/if_ack   : fetched word, one-cycle completion pulse
//   dm_req/we/addr/wdata : data request (level), direction, address, write data
//   dm_rdata/dm_ack   : read data, one-cycle completion pulse
//   mem_*             : memory enable / write enable / address / data / read data
//   stall_if/stall_mem: request pending and not yet acknowledged
//   busy              : arbiter not in IDLE
// Build option: MEM_ARB_RR_EN selects round-robin tie-breaking; without it the
// data port always wins a tie.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int IF_ADDR_W   = DEF_IF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [IF_ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0]    if_rdata,
    output logic                 if_ack,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [ADDR_W-1:0]    dm_addr,
    input  logic [DATA_W-1:0]    dm_wdata,
    output logic [DATA_W-1:0]    dm_rdata,
    output logic                 dm_ack,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 stall_if,
    output logic                 stall_mem,
    output logic                 busy
);

    state_t              state_q;
    gnt_t                gnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;
    logic                if_ack_q, dm_ack_q;
    logic                pick_dm;
    logic                any_req;
    logic                cnt_done;

    assign any_req = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
    // Most recent grant; resets to data so the first tie goes to fetch.
    gnt_t last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_q <= GNT_DM;
        else if (state_q == IDLE && any_req)
            last_q <= pick_dm ? GNT_DM : GNT_IF;
    end
`endif

    always_comb begin
        pick_dm = dm_req;
`ifdef MEM_ARB_RR_EN
        if (dm_req && if_req)
            pick_dm = (last_q == GNT_IF);
`endif
    end

    wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .reset  (reset),
        .load_i (state_q == IDLE),
        .en_i   (state_q == ACCESS),
        .done_o (cnt_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= ACCESS;
                        if (pick_dm) begin
                            gnt_q   <= GNT_DM;
                            addr_q  <= dm_addr;
                            we_q    <= dm_we;
                            wdata_q <= dm_wdata;
                        end else begin
                            gnt_q   <= GNT_IF;
                            addr_q  <= ADDR_W'(if_addr);
                            we_q    <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    // Read data is only valid on the last access cycle.
                    if (cnt_done) begin
                        state_q <= RESP;
                        if (gnt_q == GNT_DM) begin
                            dm_ack_q <= 1'b1;
                            if (!we_q) dm_rdata_q <= mem_rdata;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign busy      = (state_q != IDLE);
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = dm_req & ~dm_ack_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer sharing one single-ported 16-bit memory between the instruction-fetch port and the data-memory stage of the pipelined CPU. Serialises requests, drives the memory through a fixed wait-state access sequence and returns registered read data with a one-cycle acknowledge. Produces per-port stall signals that the hazard logic uses to freeze the PC, IF/ID and EX/MEM registers until the access completes.

## Interface
- `ADDR_W`, 16: memory address width.
- `IF_ADDR_W`, 8: fetch address width (PC width); zero-extended to `ADDR_W`.
- `DATA_W`, 16: data word width.
- `WAIT_CYCLES`, 2: extra memory cycles per access (0 allowed).
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request, level, held until `if_ack`.
- `if_addr`  in  IF_ADDR_W  fetch address, stable while `if_req`.
- `if_rdata`  out  DATA_W  fetched instruction, valid when `if_ack`.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `dm_req`  in  1  data request, level, held until `dm_ack`.
- `dm_we`  in  1  1 = write, 0 = read; stable while `dm_req`.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  write data.
- `dm_rdata`  out  DATA_W  read data, valid when `dm_ack` on a read.
- `dm_ack`  out  1  one-cycle data completion pulse.
- `mem_en`  out  1  memory access enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid on final access cycle.
- `stall_if`  out  1  `if_req & ~if_ack`, combinational.
- `stall_mem`  out  1  `dm_req & ~dm_ack`, combinational.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any request is pending, grant one and capture its address, write data and write enable into registers, then go to ACCESS; else stay.
- Default arbitration is fixed priority: data port wins any tie, because it is the older instruction in the pipeline.
- ACCESS: `mem_en`=1; `mem_addr`, `mem_we`, `mem_wdata` come from the captured registers and are stable throughout. Lasts exactly WAIT_CYCLES+1 cycles, counted by the wait counter.
- Final ACCESS edge:
  - Reads: `mem_rdata` registered into the granted port's rdata register.
  - Writes: the memory commits; `dm_rdata` is unchanged.
  - State goes to RESP.
- RESP: granted port's ack = 1 for exactly one cycle; `mem_en`=0; next state IDLE unconditionally.
- Requester deasserts req on the edge ending its ack cycle. A req still high in IDLE is treated as a new request.
- Only one ack is ever high in a cycle. An ungranted request waits with its stall high.
- Req dropped mid-access (protocol violation): the access completes and ack still pulses.
- `if_rdata`/`dm_rdata` hold their last value until overwritten by the next read on that port.
- Reset, asserted asynchronously at any time:
  - State goes to IDLE; counter 0; `mem_en`, `mem_we`, `if_ack`, `dm_ack`, `busy` go to 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` go to 0.
  - A write interrupted mid-ACCESS has no commit guarantee.

## Timing
- Request high in cycle 0 (IDLE, granted) → ACCESS cycles 1..WAIT_CYCLES+1 → ack in cycle WAIT_CYCLES+2 → IDLE in cycle WAIT_CYCLES+3.
- WAIT_CYCLES=2: ack in cycle 4; one port with continuous requests gets one access per 5 cycles.
- A loser waits one full access and re-arbitrates in the following IDLE cycle.
- Wait counter width is max(1, $clog2(WAIT_CYCLES+1)); it never wraps within an access.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On a tie, the port not granted most recently wins; the last-grant flag resets to "data" so the first tie goes to fetch. Neither port can be granted twice in a row while the other waits.
- Undefined: fixed data-port priority as above. A continuously requesting data port can starve fetch, which is accepted because each MEM-stage instruction issues one access.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, ACCESS, RESP);
  - grant-select encoding (GNT_IF, GNT_DM);
  - default width constants.
- One sub-module, `wait_counter`: loadable down-counter with a `done` flag on the final ACCESS cycle, parameterised by WAIT_CYCLES.
- Arbitration and FSM stay in the top module.

## Test plan
- Single fetch, WAIT_CYCLES=2, `if_addr`=8'h04, memory word 16'h1234 → `mem_addr`=16'h0004 for cycles 1–3, `if_ack` in cycle 4, `if_rdata`=16'h1234, `stall_if` high for cycles 0–3.
- Simultaneous `if_req` and `dm_req` (read 16'h0010 → 16'hBEEF) → data granted first, `dm_ack` in cycle 4; fetch granted in cycle 5 and acked in cycle 9; with `MEM_ARB_RR_EN`, fetch is served first.
- Data write of 16'hA5A5 to 16'h0020, then a read of the same address → `mem_we`=1 only during the write's ACCESS cycles; the read returns 16'hA5A5; `dm_rdata` is unchanged during the write ack.
- WAIT_CYCLES=0 → ACCESS lasts 1 cycle, ack in cycle 2, back-to-back fetches every 3 cycles.
- `reset` pulled low during cycle 2 of an ACCESS → all outputs 0 immediately; after release, a pending `if_req` is granted afresh and completes normally.
- Data port requesting continuously while fetch waits → without the macro, fetch is never acked; with `MEM_ARB_RR_EN`, grants alternate DM/IF.
